// File: rtl/imem_boot_loader_if.sv
// Byte-stream load channel and instruction-fetch channel of the boot loader.
// The master drives bytes and fetch requests; the slave is the boot loader.
interface imem_boot_loader_if #(
  parameter int XLEN = 32,
  parameter int AW   = 8
);
  logic            ld_valid;
  logic            ld_ready;
  logic [7:0]      ld_byte;
  logic            ld_last;
  logic            fetch_en;
  logic [AW+1:0]   fetch_addr;
  logic            fetch_valid;
  logic [XLEN-1:0] fetch_data;
  logic            fetch_misalign;

  modport master (
    output ld_valid, ld_byte, ld_last, fetch_en, fetch_addr,
    input  ld_ready, fetch_valid, fetch_data, fetch_misalign
  );

  modport slave (
    input  ld_valid, ld_byte, ld_last, fetch_en, fetch_addr,
    output ld_ready, fetch_valid, fetch_data, fetch_misalign
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader: assembles a byte-serial image into
// little-endian XLEN words, keeps the core in reset until the load plus a
// hold time is over, then serves registered instruction fetches.
module imem_boot_loader #(
  parameter int              XLEN       = 32,
  parameter int              DEPTH      = 256,
  parameter int              RESET_HOLD = 4,
  parameter logic [XLEN-1:0] FILL       = XLEN'(32'h0000_0013)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  imem_boot_loader_if.slave        bus,
  input  logic                     reload,
  output logic                     cpu_reset_n,
  output logic                     load_done,
  output logic                     load_err,
  output logic [$clog2(DEPTH):0]   word_count
);
  localparam int LANES = XLEN / 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int LB    = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int HW    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  typedef enum logic [1:0] {S_LOAD, S_HOLD, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [HW-1:0]     hold_cnt;
  logic [LW-1:0]     lane;
  logic [XLEN-1:0]   stage;
  logic              last_seen;
  logic [XLEN-1:0]   mem [DEPTH];

  logic              take;
  logic              word_full;
  logic              mem_we;
  logic [XLEN-1:0]   mem_wdata;
  logic [AW-1:0]     fetch_idx;
  logic              misalign;
  logic              fetch_go;
  logic              fv_q, fm_q;
  logic [XLEN-1:0]   fd_q;

  assign bus.ld_ready       = (state_q == S_LOAD);
  assign load_done          = (state_q == S_RUN);
  assign cpu_reset_n        = (state_q == S_RUN);
  assign bus.fetch_valid    = fv_q;
  assign bus.fetch_data     = fd_q;
  assign bus.fetch_misalign = fm_q;

  // A byte that arrives after ld_last (while the FSM is still leaving LOAD)
  // is handshaken but dropped; reload always discards the concurrent byte.
  assign take      = bus.ld_valid && bus.ld_ready && !reload && !last_seen;
  assign word_full = (word_count == (AW+1)'(DEPTH));
  // stage is zero above the current lane, so OR-ing in the new byte also
  // yields the zero-padded word when ld_last closes a partial word.
  assign mem_wdata = stage | (XLEN'(bus.ld_byte) << {lane, 3'b000});
  assign mem_we    = take && !word_full &&
                     ((lane == LW'(LANES - 1)) || bus.ld_last);

  assign fetch_idx = AW'(bus.fetch_addr >> LB);
  assign misalign  = |(bus.fetch_addr & (AW+2)'(LANES - 1));
  assign fetch_go  = bus.fetch_en && (state_q == S_RUN) && !reload;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_LOAD;
    else          state_q <= state_d;
  end

  // Next-state decode; reload overrides every other transition.
  // NOTE: state_d is defaulted first so no path through the block can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (last_seen)        state_d = S_HOLD;
      S_HOLD:  if (hold_cnt == '0)   state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_LOAD;
    endcase
    if (reload) state_d = S_LOAD;
  end

  // Hold countdown: preloaded outside HOLD so HOLD lasts exactly RESET_HOLD cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                hold_cnt <= HW'(RESET_HOLD - 1);
    else if (state_q != S_HOLD)  hold_cnt <= HW'(RESET_HOLD - 1);
    else if (hold_cnt != '0)     hold_cnt <= hold_cnt - HW'(1);
  end

  // Byte assembly, word counting, overflow flag and end-of-image tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane       <= '0;
      stage      <= '0;
      word_count <= '0;
      load_err   <= 1'b0;
      last_seen  <= 1'b0;
    end else if (reload) begin
      lane       <= '0;
      stage      <= '0;
      word_count <= '0;
      load_err   <= 1'b0;
      last_seen  <= 1'b0;
    end else begin
      if (take) begin
        if (word_full) begin
          load_err <= 1'b1;
        end else if (mem_we) begin
          word_count <= word_count + (AW+1)'(1);
          lane       <= '0;
          stage      <= '0;
        end else begin
          lane  <= lane + LW'(1);
          stage <= mem_wdata;
        end
      end
      last_seen <= (state_d == S_LOAD) && (last_seen || (take && bus.ld_last));
    end
  end

  // Image storage; the write pointer is the low bits of word_count.
  // NOTE: the array has no reset; word_count alone decides what is visible.
  always_ff @(posedge clk) begin
    if (mem_we) mem[word_count[AW-1:0]] <= mem_wdata;
  end

  // Registered fetch port: one result per accepted request, FILL beyond the image.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fv_q <= 1'b0;
      fm_q <= 1'b0;
      fd_q <= '0;
    end else begin
      fv_q <= fetch_go;
      if (fetch_go) begin
        fm_q <= misalign;
        if (misalign)                           fd_q <= FILL;
        else if ({1'b0, fetch_idx} < word_count) fd_q <= mem[fetch_idx];
        else                                     fd_q <= FILL;
      end
    end
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: a DEPTH=256 instance for load, hold,
// fetch, reload and async-reset scenarios and a DEPTH=2 instance for overflow.
module tb_imem_boot_loader;
  localparam logic [31:0] FILL = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset_n_a = 1'b0, reset_n_b = 1'b0;
  logic reload_a = 1'b0, reload_b = 1'b0;
  logic cpu_reset_n_a, load_done_a, load_err_a;
  logic cpu_reset_n_b, load_done_b, load_err_b;
  logic [8:0] word_count_a;
  logic [1:0] word_count_b;
  int total = 0;
  int bad = 0;

  imem_boot_loader_if #(.XLEN(32), .AW(8)) ifa ();
  imem_boot_loader_if #(.XLEN(32), .AW(1)) ifb ();

  imem_boot_loader #(.XLEN(32), .DEPTH(256), .RESET_HOLD(4), .FILL(FILL)) dut_a (
    .clk(clk), .reset_n(reset_n_a), .bus(ifa), .reload(reload_a),
    .cpu_reset_n(cpu_reset_n_a), .load_done(load_done_a),
    .load_err(load_err_a), .word_count(word_count_a));

  imem_boot_loader #(.XLEN(32), .DEPTH(2), .RESET_HOLD(4), .FILL(FILL)) dut_b (
    .clk(clk), .reset_n(reset_n_b), .bus(ifb), .reload(reload_b),
    .cpu_reset_n(cpu_reset_n_b), .load_done(load_done_b),
    .load_err(load_err_b), .word_count(word_count_b));

  always #5 clk = ~clk;

  // Drive one byte for one edge; returns 1 ns after that edge.
  task automatic a_byte(input logic [7:0] b, input logic last);
    ifa.ld_valid = 1'b1; ifa.ld_byte = b; ifa.ld_last = last;
    @(posedge clk); #1;
    ifa.ld_valid = 1'b0; ifa.ld_last = 1'b0;
  endtask

  task automatic b_byte(input logic [7:0] b, input logic last);
    ifb.ld_valid = 1'b1; ifb.ld_byte = b; ifb.ld_last = last;
    @(posedge clk); #1;
    ifb.ld_valid = 1'b0; ifb.ld_last = 1'b0;
  endtask

  task automatic a_fetch(input logic [9:0] addr, output logic v, output logic [31:0] d, output logic m);
    ifa.fetch_en = 1'b1; ifa.fetch_addr = addr;
    @(posedge clk); #1;
    ifa.fetch_en = 1'b0;
    v = ifa.fetch_valid; d = ifa.fetch_data; m = ifa.fetch_misalign;
  endtask

  task automatic b_fetch(input logic [2:0] addr, output logic v, output logic [31:0] d);
    ifb.fetch_en = 1'b1; ifb.fetch_addr = addr;
    @(posedge clk); #1;
    ifb.fetch_en = 1'b0;
    v = ifb.fetch_valid; d = ifb.fetch_data;
  endtask

  task automatic a_reload();
    reload_a = 1'b1; @(posedge clk); #1; reload_a = 1'b0;
  endtask

  task automatic wait_run_a(input string tag);
    int n = 0;
    while (load_done_a !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    total++; if (load_done_a !== 1'b1) begin bad++; $display("FAIL %s_run_timeout got=%b exp=1", tag, load_done_a); end
  endtask

  task automatic wait_run_b(input string tag);
    int n = 0;
    while (load_done_b !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    total++; if (load_done_b !== 1'b1) begin bad++; $display("FAIL %s_run_timeout got=%b exp=1", tag, load_done_b); end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk); #1;
    total++; if (ifa.ld_ready !== 1'b1) begin bad++; $display("FAIL rst_ld_ready got=%b exp=1", ifa.ld_ready); end
    total++; if (ifa.fetch_valid !== 1'b0) begin bad++; $display("FAIL rst_fetch_valid got=%b exp=0", ifa.fetch_valid); end
    total++; if (ifa.fetch_data !== 32'h0) begin bad++; $display("FAIL rst_fetch_data got=%h exp=0", ifa.fetch_data); end
    total++; if (ifa.fetch_misalign !== 1'b0) begin bad++; $display("FAIL rst_misalign got=%b exp=0", ifa.fetch_misalign); end
    total++; if (cpu_reset_n_a !== 1'b0) begin bad++; $display("FAIL rst_cpu_reset_n got=%b exp=0", cpu_reset_n_a); end
    total++; if (load_done_a !== 1'b0) begin bad++; $display("FAIL rst_load_done got=%b exp=0", load_done_a); end
    total++; if (load_err_a !== 1'b0) begin bad++; $display("FAIL rst_load_err got=%b exp=0", load_err_a); end
    total++; if (word_count_a !== 9'd0) begin bad++; $display("FAIL rst_word_count got=%0d exp=0", word_count_a); end
    reset_n_a = 1'b1; reset_n_b = 1'b1;
    @(posedge clk); #1;
    total++; if (cpu_reset_n_a !== 1'b0) begin bad++; $display("FAIL rst_idle_cpu_reset_n got=%b exp=0", cpu_reset_n_a); end
  endtask

  task automatic test_load_basic();
    logic [7:0] img [8];
    img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    for (int i = 0; i < 8; i++) begin
      a_byte(img[i], i == 7);
      if (i == 3) begin
        total++; if (word_count_a !== 9'd1) begin bad++; $display("FAIL load_wc_first_word got=%0d exp=1", word_count_a); end
      end
    end
    total++; if (word_count_a !== 9'd2) begin bad++; $display("FAIL load_word_count got=%0d exp=2", word_count_a); end
    total++; if (load_err_a !== 1'b0) begin bad++; $display("FAIL load_err got=%b exp=0", load_err_a); end
    total++; if (ifa.ld_ready !== 1'b1) begin bad++; $display("FAIL load_ready_edge_n got=%b exp=1", ifa.ld_ready); end
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      total++; if (cpu_reset_n_a !== 1'b0) begin bad++; $display("FAIL hold_cpu_reset_n_%0d got=%b exp=0", k, cpu_reset_n_a); end
      if (k == 1) begin
        total++; if (ifa.ld_ready !== 1'b0) begin bad++; $display("FAIL hold_ld_ready got=%b exp=0", ifa.ld_ready); end
      end
    end
    @(posedge clk); #1;
    total++; if (cpu_reset_n_a !== 1'b1) begin bad++; $display("FAIL run_cpu_reset_n got=%b exp=1", cpu_reset_n_a); end
    total++; if (load_done_a !== 1'b1) begin bad++; $display("FAIL run_load_done got=%b exp=1", load_done_a); end
  endtask

  task automatic test_back_to_back();
    logic [9:0]  addrs [4];
    logic [31:0] exp_d [4];
    logic        exp_m [4];
    addrs = '{10'd0, 10'd4, 10'd8, 10'd6};
    exp_d = '{32'h0000_0013, 32'h0010_0093, FILL, FILL};
    exp_m = '{1'b0, 1'b0, 1'b0, 1'b1};
    ifa.fetch_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ifa.fetch_addr = addrs[i];
      @(posedge clk); #1;
      total++; if (ifa.fetch_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid_%0d got=%b exp=1", i, ifa.fetch_valid); end
      total++; if (ifa.fetch_data !== exp_d[i]) begin bad++; $display("FAIL b2b_data_%0d got=%h exp=%h", i, ifa.fetch_data, exp_d[i]); end
      total++; if (ifa.fetch_misalign !== exp_m[i]) begin bad++; $display("FAIL b2b_misalign_%0d got=%b exp=%b", i, ifa.fetch_misalign, exp_m[i]); end
    end
    ifa.fetch_en = 1'b0;
    @(posedge clk); #1;
    total++; if (ifa.fetch_valid !== 1'b0) begin bad++; $display("FAIL b2b_valid_drop got=%b exp=0", ifa.fetch_valid); end
  endtask

  task automatic test_partial();
    logic v, m; logic [31:0] d;
    a_reload();
    a_byte(8'hAA, 1'b0); a_byte(8'hBB, 1'b0); a_byte(8'hCC, 1'b1);
    total++; if (word_count_a !== 9'd1) begin bad++; $display("FAIL partial_word_count got=%0d exp=1", word_count_a); end
    wait_run_a("partial");
    a_fetch(10'd0, v, d, m);
    total++; if (v !== 1'b1 || d !== 32'h00CC_BBAA) begin bad++; $display("FAIL partial_word0 got=%b/%h exp=1/00ccbbaa", v, d); end
    a_fetch(10'd4, v, d, m);
    total++; if (d !== FILL) begin bad++; $display("FAIL partial_gated_word1 got=%h exp=%h", d, FILL); end
  endtask

  task automatic test_reset_midload();
    logic v, m; logic [31:0] d;
    a_reload();
    a_byte(8'hDE, 1'b0); a_byte(8'hAD, 1'b0); a_byte(8'hBE, 1'b0); a_byte(8'hEF, 1'b0); a_byte(8'h55, 1'b0);
    total++; if (word_count_a !== 9'd1) begin bad++; $display("FAIL midrst_pre_wc got=%0d exp=1", word_count_a); end
    reset_n_a = 1'b0; #1;
    total++; if (word_count_a !== 9'd0) begin bad++; $display("FAIL midrst_async_wc got=%0d exp=0", word_count_a); end
    total++; if (ifa.ld_ready !== 1'b1) begin bad++; $display("FAIL midrst_ld_ready got=%b exp=1", ifa.ld_ready); end
    @(posedge clk); #1; reset_n_a = 1'b1;
    a_byte(8'h11, 1'b0); a_byte(8'h22, 1'b0); a_byte(8'h33, 1'b0); a_byte(8'h44, 1'b1);
    total++; if (word_count_a !== 9'd1) begin bad++; $display("FAIL midrst_reload_wc got=%0d exp=1", word_count_a); end
    wait_run_a("midrst");
    a_fetch(10'd0, v, d, m);
    total++; if (d !== 32'h4433_2211) begin bad++; $display("FAIL midrst_word0 got=%h exp=44332211", d); end
  endtask

  task automatic test_reload();
    logic v, m; logic [31:0] d;
    reload_a = 1'b1; ifa.fetch_en = 1'b1; ifa.fetch_addr = 10'd4;
    @(posedge clk); #1; reload_a = 1'b0;
    total++; if (cpu_reset_n_a !== 1'b0) begin bad++; $display("FAIL reload_cpu_reset_n got=%b exp=0", cpu_reset_n_a); end
    total++; if (load_done_a !== 1'b0) begin bad++; $display("FAIL reload_load_done got=%b exp=0", load_done_a); end
    total++; if (ifa.fetch_valid !== 1'b0) begin bad++; $display("FAIL reload_fetch_same_edge got=%b exp=0", ifa.fetch_valid); end
    total++; if (word_count_a !== 9'd0) begin bad++; $display("FAIL reload_word_count got=%0d exp=0", word_count_a); end
    @(posedge clk); #1; ifa.fetch_en = 1'b0;
    total++; if (ifa.fetch_valid !== 1'b0) begin bad++; $display("FAIL reload_fetch_in_load got=%b exp=0", ifa.fetch_valid); end
    // Byte coincident with reload must be discarded.
    reload_a = 1'b1; ifa.ld_valid = 1'b1; ifa.ld_byte = 8'hEE; ifa.ld_last = 1'b0;
    @(posedge clk); #1; reload_a = 1'b0; ifa.ld_valid = 1'b0;
    a_byte(8'h01, 1'b0); a_byte(8'h02, 1'b0); a_byte(8'h03, 1'b0); a_byte(8'h04, 1'b1);
    wait_run_a("reload");
    a_fetch(10'd0, v, d, m);
    total++; if (v !== 1'b1 || d !== 32'h0403_0201) begin bad++; $display("FAIL reload_word0 got=%b/%h exp=1/04030201", v, d); end
    a_fetch(10'd4, v, d, m);
    total++; if (d !== FILL) begin bad++; $display("FAIL reload_word1_fill got=%h exp=%h", d, FILL); end
  endtask

  task automatic test_overflow();
    logic v; logic [31:0] d;
    for (int i = 0; i < 12; i++) begin
      total++; if (ifb.ld_ready !== 1'b1) begin bad++; $display("FAIL ovf_ld_ready_%0d got=%b exp=1", i, ifb.ld_ready); end
      b_byte(8'(i + 1), i == 11);
      if (i == 8) begin
        total++; if (load_err_b !== 1'b1) begin bad++; $display("FAIL ovf_err_first got=%b exp=1", load_err_b); end
      end
    end
    total++; if (word_count_b !== 2'd2) begin bad++; $display("FAIL ovf_word_count got=%0d exp=2", word_count_b); end
    total++; if (load_err_b !== 1'b1) begin bad++; $display("FAIL ovf_load_err got=%b exp=1", load_err_b); end
    wait_run_b("ovf");
    b_fetch(3'd0, v, d);
    total++; if (d !== 32'h0403_0201) begin bad++; $display("FAIL ovf_word0 got=%h exp=04030201", d); end
    b_fetch(3'd4, v, d);
    total++; if (d !== 32'h0807_0605) begin bad++; $display("FAIL ovf_word1 got=%h exp=08070605", d); end
  endtask

  initial begin
    ifa.ld_valid = 1'b0; ifa.ld_byte = '0; ifa.ld_last = 1'b0; ifa.fetch_en = 1'b0; ifa.fetch_addr = '0;
    ifb.ld_valid = 1'b0; ifb.ld_byte = '0; ifb.ld_last = 1'b0; ifb.fetch_en = 1'b0; ifb.fetch_addr = '0;
    test_reset();
    test_load_basic();
    test_back_to_back();
    test_partial();
    test_reset_midload();
    test_reload();
    test_overflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
